// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl -- sequencer for the 4-bank x 10-tap reconfigurable FIR.
//
// Loads NBANK banks of NTAP coefficients from a host valid/ready stream.
// Each bank is buffered, then written to the filter as an (NTAP+1)-cycle
// update burst that starts with a zero word. GAP idle cycles follow each
// burst. In run mode every accepted sample strobe becomes a one-cycle FirIn
// pulse plus an (NTAP+1)-cycle read/MAC window on the latched bank.
//
// Ports
//   iClk12M, iRst         12 MHz clock, asynchronous active-high reset
//   iEnSample600k         one-cycle sample strobe
//   iCfgStart             pulse, starts a full coefficient load
//   iCoefValid/iCoefData  host coefficient stream, oCoefReady accepts it
//   iRunEn                level, enables sample sequencing
//   iBankSel/iPulseIn     bank and symbol captured at each served strobe
//   oCoeffUpdateFlag/oWtDtRam/oMemRdFlag/oModuleSel/oFirIn  filter controls
//   oLoadDone             one-cycle pulse when the full load has finished
//   oBusy                 high outside IDLE and RUN_WAIT
//   oSampleMiss           sticky, a strobe was dropped
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for the first load request
// COLLECT  | accepting NTAP coefficients of the current bank
// WRITE    | update burst, zero word then the NTAP buffered words
// GAP      | GAP quiet cycles after a burst
// RUN_WAIT | all banks loaded, waiting for a strobe or a reload
// RUN_RD   | read/MAC window for one sample

module fir_seq_ctrl #(
    parameter int NTAP  = 10,
    parameter int NBANK = 4,
    parameter int GAP   = 5
) (
    input  logic        iClk12M,
    input  logic        iRst,
    input  logic        iEnSample600k,
    input  logic        iCfgStart,
    input  logic        iCoefValid,
    input  logic [15:0] iCoefData,
    output logic        oCoefReady,
    input  logic        iRunEn,
    input  logic [1:0]  iBankSel,
    input  logic [2:0]  iPulseIn,
    output logic        oCoeffUpdateFlag,
    output logic [15:0] oWtDtRam,
    output logic        oMemRdFlag,
    output logic [1:0]  oModuleSel,
    output logic [2:0]  oFirIn,
    output logic        oLoadDone,
    output logic        oBusy,
    output logic        oSampleMiss
);

    localparam int TMAX = (NTAP > GAP) ? NTAP : GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(NTAP + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_COLLECT  = 3'd1;
    localparam logic [2:0] S_WRITE    = 3'd2;
    localparam logic [2:0] S_GAP      = 3'd3;
    localparam logic [2:0] S_RUN_WAIT = 3'd4;
    localparam logic [2:0] S_RUN_RD   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    bank_q, bank_d;
    logic [1:0]    rbank_q, rbank_d;
    logic [2:0]    rpulse_q, rpulse_d;
    logic          pend_q, pend_d;
    logic [15:0]   coef_q [NTAP];

    logic          ready_q, ready_d;
    logic          upd_q, upd_d;
    logic [15:0]   wdat_q, wdat_d;
    logic          mrd_q, mrd_d;
    logic [1:0]    msel_q, msel_d;
    logic [2:0]    firin_q, firin_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          miss_q, miss_d;

    logic          accept;
    logic          start_req;
    logic [CW-1:0] widx;

    // ready is only ever high in COLLECT, so this is the handshake
    assign accept    = ready_q & iCoefValid;
    // a reload requested during a read window is replayed from RUN_WAIT
    assign start_req = iCfgStart | pend_q;
    // the timer counts NTAP..0 through a burst; word index trails by one
    assign widx      = CW'(NTAP - 1) - CW'(tmr_q);

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        cnt_d    = cnt_q;
        bank_d   = bank_q;
        rbank_d  = rbank_q;
        rpulse_d = rpulse_q;
        pend_d   = pend_q;
        ready_d  = 1'b0;
        upd_d    = 1'b0;
        wdat_d   = 16'h0000;
        mrd_d    = 1'b0;
        msel_d   = msel_q;
        firin_d  = 3'b000;
        done_d   = 1'b0;
        miss_d   = miss_q;

        if (iEnSample600k && (state_q inside {S_COLLECT, S_WRITE, S_GAP, S_RUN_RD}))
            miss_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (iCfgStart) begin
                    state_d = S_COLLECT;
                    bank_d  = 2'd0;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end
            end
            S_COLLECT: begin
                ready_d = 1'b1;
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(NTAP - 1)) begin
                        ready_d = 1'b0;
                        state_d = S_WRITE;
                        tmr_d   = TW'(NTAP);
                    end
                end
            end
            S_WRITE: begin
                upd_d  = 1'b1;
                msel_d = bank_q;
                wdat_d = (tmr_q == TW'(NTAP)) ? 16'h0000 : coef_q[widx];
                if (tmr_q == '0) begin
                    state_d = S_GAP;
                    tmr_d   = TW'(GAP - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_q == '0) begin
                    if (bank_q != 2'(NBANK - 1)) begin
                        bank_d  = bank_q + 1'b1;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                        state_d = S_COLLECT;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_RUN_WAIT;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_RUN_WAIT: begin
                if (start_req) begin
                    // reload wins; a coincident enabled strobe is lost
                    if (iEnSample600k && iRunEn)
                        miss_d = 1'b1;
                    state_d = S_COLLECT;
                    bank_d  = 2'd0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    ready_d = 1'b1;
                end else if (iEnSample600k && iRunEn) begin
                    rbank_d  = iBankSel;
                    rpulse_d = iPulseIn;
                    tmr_d    = TW'(NTAP);
                    state_d  = S_RUN_RD;
                end
            end
            S_RUN_RD: begin
                mrd_d   = 1'b1;
                msel_d  = rbank_q;
                firin_d = (tmr_q == TW'(NTAP)) ? rpulse_q : 3'b000;
                if (iCfgStart)
                    pend_d = 1'b1;
                if (tmr_q == '0)
                    state_d = S_RUN_WAIT;
                else
                    tmr_d = tmr_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = !((state_d == S_IDLE) || (state_d == S_RUN_WAIT));
    end

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            cnt_q    <= '0;
            bank_q   <= '0;
            rbank_q  <= '0;
            rpulse_q <= '0;
            pend_q   <= 1'b0;
            ready_q  <= 1'b0;
            upd_q    <= 1'b0;
            wdat_q   <= '0;
            mrd_q    <= 1'b0;
            msel_q   <= '0;
            firin_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            bank_q   <= bank_d;
            rbank_q  <= rbank_d;
            rpulse_q <= rpulse_d;
            pend_q   <= pend_d;
            ready_q  <= ready_d;
            upd_q    <= upd_d;
            wdat_q   <= wdat_d;
            mrd_q    <= mrd_d;
            msel_q   <= msel_d;
            firin_q  <= firin_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            miss_q   <= miss_d;
        end
    end

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < NTAP; i++)
                coef_q[i] <= '0;
        end else if (accept) begin
            coef_q[cnt_q] <= iCoefData;
        end
    end

    assign oCoefReady       = ready_q;
    assign oCoeffUpdateFlag = upd_q;
    assign oWtDtRam         = wdat_q;
    assign oMemRdFlag       = mrd_q;
    assign oModuleSel       = msel_q;
    assign oFirIn           = firin_q;
    assign oLoadDone        = done_q;
    assign oBusy            = busy_q;
    assign oSampleMiss      = miss_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
module tb_fir_seq_ctrl;

    logic        iClk12M;
    logic        iRst;
    logic        iEnSample600k;
    logic        iCfgStart;
    logic        iCoefValid;
    logic [15:0] iCoefData;
    logic        oCoefReady;
    logic        iRunEn;
    logic [1:0]  iBankSel;
    logic [2:0]  iPulseIn;
    logic        oCoeffUpdateFlag;
    logic [15:0] oWtDtRam;
    logic        oMemRdFlag;
    logic [1:0]  oModuleSel;
    logic [2:0]  oFirIn;
    logic        oLoadDone;
    logic        oBusy;
    logic        oSampleMiss;

    fir_seq_ctrl dut (
        .iClk12M          (iClk12M),
        .iRst             (iRst),
        .iEnSample600k    (iEnSample600k),
        .iCfgStart        (iCfgStart),
        .iCoefValid       (iCoefValid),
        .iCoefData        (iCoefData),
        .oCoefReady       (oCoefReady),
        .iRunEn           (iRunEn),
        .iBankSel         (iBankSel),
        .iPulseIn         (iPulseIn),
        .oCoeffUpdateFlag (oCoeffUpdateFlag),
        .oWtDtRam         (oWtDtRam),
        .oMemRdFlag       (oMemRdFlag),
        .oModuleSel       (oModuleSel),
        .oFirIn           (oFirIn),
        .oLoadDone        (oLoadDone),
        .oBusy            (oBusy),
        .oSampleMiss      (oSampleMiss)
    );

    initial iClk12M = 1'b0;
    always #5 iClk12M = ~iClk12M;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] coef [4][10];
    logic [1:0]  m_msel = 2'd0;
    logic        m_miss = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input logic er, input logic eu, input logic [15:0] ew,
                            input logic em, input logic [2:0] ef, input logic ed,
                            input logic eb);
        chk("ready", 32'(oCoefReady), 32'(er));
        chk("upd_flag", 32'(oCoeffUpdateFlag), 32'(eu));
        chk("wt_data", 32'(oWtDtRam), 32'(ew));
        chk("memrd", 32'(oMemRdFlag), 32'(em));
        chk("module_sel", 32'(oModuleSel), 32'(m_msel));
        chk("fir_in", 32'(oFirIn), 32'(ef));
        chk("load_done", 32'(oLoadDone), 32'(ed));
        chk("busy", 32'(oBusy), 32'(eb));
        chk("sample_miss", 32'(oSampleMiss), 32'(m_miss));
    endtask

    // one clock edge, then check every output 1 time unit later
    task automatic step_chk(input logic er, input logic eu, input logic [15:0] ew,
                            input logic em, input logic [2:0] ef, input logic ed,
                            input logic eb);
        @(posedge iClk12M);
        #1;
        chk_outs(er, eu, ew, em, ef, ed, eb);
    endtask

    // Full 4-bank load. Expected timing: each bank is 10 accepts, an 11-word
    // burst (zero, then the bank's words in order) and a 5-cycle gap.
    task automatic do_load(input bit started, input bit stall3, input bit fixed, input bit abort);
        int n;
        int drop;
        bit v;
        if (!started) begin
            iCfgStart = 1'b1;
            step_chk(1, 0, 16'h0, 0, 3'h0, 0, 1);
            iCfgStart = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++)
                coef[b][i] = fixed ? 16'(16'h0A00 + 256 * b + i) : 16'($urandom);
            n = 0;
            drop = 0;
            while (n < 10) begin
                v = (drop == 0);
                if (!v) drop--;
                iCoefValid = v;
                iCoefData  = v ? coef[b][n] : 16'($urandom);
                if (v) n++;
                if (stall3 && v && n == 4) drop = 3;
                step_chk(!(v && n == 10), 0, 16'h0, 0, 3'h0, 0, 1);
            end
            iCoefValid = 1'b0;
            for (int k = 0; k < 11; k++) begin
                if (abort && k == 3) return;
                m_msel = 2'(b);
                step_chk(0, 1, (k == 0) ? 16'h0 : coef[b][k - 1], 0, 3'h0, 0, 1);
            end
            for (int g = 0; g < 5; g++)
                step_chk(g == 4 && b < 3, 0, 16'h0, 0, 3'h0, g == 4 && b == 3,
                         !(g == 4 && b == 3));
        end
        step_chk(0, 0, 16'h0, 0, 3'h0, 0, 0);
    endtask

    // One 20-cycle sample period starting with an accepted strobe.
    task automatic run_sample(input logic [1:0] bank, input logic [2:0] pulse,
                              input int extra_at, input int cfg_at, input bit wiggle);
        iEnSample600k = 1'b1;
        iRunEn        = 1'b1;
        iBankSel      = bank;
        iPulseIn      = pulse;
        step_chk(0, 0, 16'h0, 0, 3'h0, 0, 1);
        for (int r = 0; r < 11; r++) begin
            if (wiggle) begin
                iBankSel = 2'($urandom);
                iPulseIn = 3'($urandom);
            end
            iEnSample600k = (r + 1 == extra_at);
            if (r + 1 == extra_at) m_miss = 1'b1;
            iCfgStart = (r == cfg_at);
            if (r == 0) m_msel = bank;
            step_chk(0, 0, 16'h0, 1, (r == 0) ? pulse : 3'h0, 0, r < 10);
        end
        iEnSample600k = 1'b0;
        iCfgStart     = 1'b0;
        if (cfg_at >= 0) begin
            step_chk(1, 0, 16'h0, 0, 3'h0, 0, 1);
        end else begin
            for (int i = 0; i < 8; i++) begin
                iBankSel = 2'($urandom);
                step_chk(0, 0, 16'h0, 0, 3'h0, 0, 0);
            end
        end
    endtask

    initial begin
        iRst          = 1'b1;
        iEnSample600k = 1'b0;
        iCfgStart     = 1'b0;
        iCoefValid    = 1'b0;
        iCoefData     = 16'h0;
        iRunEn        = 1'b0;
        iBankSel      = 2'd0;
        iPulseIn      = 3'd0;
        #1;
        chk_outs(0, 0, 16'h0, 0, 3'h0, 0, 0);
        repeat (3) @(posedge iClk12M);
        #1;
        iRst = 1'b0;
        step_chk(0, 0, 16'h0, 0, 3'h0, 0, 0);

        // strobe before any load is not served and not a miss
        iEnSample600k = 1'b1;
        iRunEn        = 1'b1;
        step_chk(0, 0, 16'h0, 0, 3'h0, 0, 0);
        iEnSample600k = 1'b0;
        step_chk(0, 0, 16'h0, 0, 3'h0, 0, 0);

        // no-stall load with the fixed coefficient pattern
        do_load(0, 0, 1, 0);

        run_sample(2'd0, 3'b111, -1, -1, 0);
        run_sample(2'd0, 3'b000, -1, -1, 0);

        // strobe with run disabled is ignored
        iEnSample600k = 1'b1;
        iRunEn        = 1'b0;
        step_chk(0, 0, 16'h0, 0, 3'h0, 0, 0);
        iEnSample600k = 1'b0;
        step_chk(0, 0, 16'h0, 0, 3'h0, 0, 0);

        // bank sweep with random symbols and mid-window input changes
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 10; i++)
                run_sample(2'(b), 3'($urandom_range(0, 7)), -1, -1, 1);

        // extra strobe 5 cycles into a window, then a regular one
        run_sample(2'd1, 3'd5, 5, -1, 0);
        run_sample(2'd2, 3'd3, -1, -1, 0);

        // reload requested at window cycle 3, stalling host, random data
        run_sample(2'd3, 3'd6, -1, 3, 0);
        do_load(1, 1, 0, 0);
        run_sample(2'd1, 3'd2, -1, -1, 0);

        // reset asserted in the middle of a bank-0 burst
        do_load(0, 0, 0, 1);
        #2;
        iRst = 1'b1;
        #1;
        m_miss = 1'b0;
        m_msel = 2'd0;
        chk_outs(0, 0, 16'h0, 0, 3'h0, 0, 0);
        @(posedge iClk12M);
        #1;
        iRst = 1'b0;
        step_chk(0, 0, 16'h0, 0, 3'h0, 0, 0);

        do_load(0, 0, 0, 0);

        // reload and enabled strobe in the same cycle: load wins, strobe missed
        iCfgStart     = 1'b1;
        iEnSample600k = 1'b1;
        iRunEn        = 1'b1;
        m_miss        = 1'b1;
        step_chk(1, 0, 16'h0, 0, 3'h0, 0, 1);
        iCfgStart     = 1'b0;
        iEnSample600k = 1'b0;
        do_load(1, 0, 0, 0);
        run_sample(2'd2, 3'd4, -1, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
